// File: rtl/pulse_stretch.sv
// ============================================================================
// Module   : pulse_stretch
// Purpose  : Stretches single-cycle pulses into HOLD_CYCLES-long levels that are
//            separated by at least GAP_CYCLES low cycles. Pulses that arrive early
//            are queued and replayed in arrival order.
// Option   : define PULSE_STRETCH_RETRIGGER_EN to extend the level on in=1 during HOLD
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_stretch #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              in,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]  c_hold_load = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_gap_load  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PEND_W-1:0] c_pend_max  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out;
  logic               r_busy;
  logic [PEND_W-1:0]  r_pending;
  logic               r_overflow;

  state_t             w_nxt_state;
  logic [CNT_W-1:0]   w_nxt_cnt;
  logic [PEND_W-1:0]  w_nxt_pend;
  logic               w_nxt_ovf;
  logic               w_consume;
  logic               w_queue;
  logic               w_cnt_zero;
  logic               w_pend_nz;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_pend_nz  = (r_pending != '0);

  // w_queue marks a request that must wait; w_consume marks a queued one being started.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_consume   = 1'b0;
    w_queue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in) begin
          w_nxt_state = S_HOLD;
          w_nxt_cnt   = c_hold_load;
        end
      end
      S_HOLD: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (in) begin
          w_nxt_cnt = c_hold_load;
        end else
`endif
        if (!w_cnt_zero) begin
          w_nxt_cnt = r_cnt - CNT_W'(1);
          w_queue   = in;
        end else if (GAP_CYCLES > 0) begin
          w_nxt_state = S_GAP;
          w_nxt_cnt   = c_gap_load;
          w_queue     = in;
        end else if (w_pend_nz) begin
          w_nxt_cnt = c_hold_load;
          w_consume = 1'b1;
          w_queue   = in;
        end else if (in) begin
          w_nxt_cnt = c_hold_load;
        end else begin
          w_nxt_state = S_IDLE;
          w_nxt_cnt   = '0;
        end
      end
      S_GAP: begin
        if (!w_cnt_zero) begin
          w_nxt_cnt = r_cnt - CNT_W'(1);
          w_queue   = in;
        end else if (w_pend_nz) begin
          w_nxt_state = S_HOLD;
          w_nxt_cnt   = c_hold_load;
          w_consume   = 1'b1;
          w_queue     = in;
        end else if (in) begin
          w_nxt_state = S_HOLD;
          w_nxt_cnt   = c_hold_load;
        end else begin
          w_nxt_state = S_IDLE;
          w_nxt_cnt   = '0;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // A queued request and a consume in the same cycle cancel: the new one takes the slot.
  always_comb begin
    w_nxt_pend = r_pending;
    w_nxt_ovf  = r_overflow;
    if (w_queue && !w_consume) begin
      if (r_pending == c_pend_max) begin
        w_nxt_ovf = 1'b1;
      end else begin
        w_nxt_pend = r_pending + PEND_W'(1);
      end
    end else if (w_consume && !w_queue) begin
      w_nxt_pend = r_pending - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_out      <= 1'b0;
      r_busy     <= 1'b0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else if (!en) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_out     <= 1'b0;
      r_busy    <= 1'b0;
      r_pending <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_out      <= (w_nxt_state == S_HOLD);
      r_busy     <= (w_nxt_state != S_IDLE);
      r_pending  <= w_nxt_pend;
      r_overflow <= w_nxt_ovf;
    end
  end

  assign out      = r_out;
  assign busy     = r_busy;
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretch.sv
// ============================================================================
// Module   : tb_pulse_stretch
// Purpose  : Directed self-checking bench for pulse_stretch (default, PEND_W=2
//            and GAP_CYCLES=0 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_stretch;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in_a, in_s, in_m;
  logic       out_a, busy_a, ovf_a;
  logic [3:0] pend_a;
  logic       out_s, busy_s, ovf_s;
  logic [1:0] pend_s;
  logic       out_m, busy_m, ovf_m;
  logic [3:0] pend_m;

  int n_checks = 0;
  int n_err    = 0;

  pulse_stretch u_dut (
    .clk(clk), .reset_n(rst_n), .en(en), .in(in_a),
    .out(out_a), .busy(busy_a), .pending(pend_a), .overflow(ovf_a)
  );

  pulse_stretch #(.PEND_W(2)) u_sat (
    .clk(clk), .reset_n(rst_n), .en(en), .in(in_s),
    .out(out_s), .busy(busy_s), .pending(pend_s), .overflow(ovf_s)
  );

  pulse_stretch #(.HOLD_CYCLES(3), .GAP_CYCLES(0)) u_mrg (
    .clk(clk), .reset_n(rst_n), .en(en), .in(in_m),
    .out(out_m), .busy(busy_m), .pending(pend_m), .overflow(ovf_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic win(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  initial begin
    int c;
    int peak;
    int highs;
    int edges;
    logic prev;

    rst_n = 1'b0; en = 1'b0; in_a = 1'b0; in_s = 1'b0; in_m = 1'b0;
    tick(); tick();
    check("rst out",      out_a,  0);
    check("rst busy",     busy_a, 0);
    check("rst pending",  pend_a, 0);
    check("rst overflow", ovf_a,  0);
    check("rst sat pend", pend_s, 0);
    check("rst mrg out",  out_m,  0);
    #3 rst_n = 1'b1;
    tick();
    en = 1'b1;
    tick();

    // single pulse: observation index k is cycle t0+k
    in_a = 1'b1; tick(); in_a = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      check($sformatf("single out c%0d", k),  out_a,  win(k, 1, 8));
      check($sformatf("single busy c%0d", k), busy_a, win(k, 1, 10));
      check($sformatf("single pend c%0d", k), pend_a, 0);
      tick();
    end

`ifdef PULSE_STRETCH_RETRIGGER_EN
    for (int k = 0; k <= 16; k++) begin
      in_a = (k == 0) || (k == 5);
      tick();
      c = k + 1;
      check($sformatf("retrig out c%0d", c),  out_a,  win(c, 1, 13));
      check($sformatf("retrig busy c%0d", c), busy_a, win(c, 1, 15));
      check($sformatf("retrig pend c%0d", c), pend_a, 0);
    end
    in_a = 1'b0;
    tick(); tick();
`else
    peak = 0;
    for (int k = 0; k <= 31; k++) begin
      in_a = (k == 0) || (k == 3) || (k == 5);
      tick();
      c = k + 1;
      if (int'(pend_a) > peak) peak = int'(pend_a);
      check($sformatf("b2b out c%0d", c), out_a, win(c, 1, 8) | win(c, 11, 18) | win(c, 21, 28));
      check($sformatf("b2b pend c%0d", c), pend_a,
            win(c, 4, 5) ? 1 : win(c, 6, 10) ? 2 : win(c, 11, 20) ? 1 : 0);
    end
    in_a = 1'b0;
    check("b2b pending peak", peak, 2);

    for (int k = 0; k <= 30; k++) begin
      in_a = (k == 0) || (k == 3) || (k == 10);
      tick();
      c = k + 1;
      check($sformatf("consume out c%0d", c), out_a, win(c, 1, 8) | win(c, 11, 18) | win(c, 21, 28));
      check($sformatf("consume pend c%0d", c), pend_a, win(c, 4, 20) ? 1 : 0);
    end
    in_a = 1'b0;
    tick(); tick();

    for (int k = 0; k <= 5; k++) begin
      in_a = (k == 0) || (k == 2) || (k == 4);
      tick();
    end
    in_a = 1'b0;
    check("en_drop pre pend", pend_a, 2);
    check("en_drop pre out",  out_a,  1);
    en = 1'b0;
    tick();
    check("en_drop out",  out_a,  0);
    check("en_drop busy", busy_a, 0);
    check("en_drop pend", pend_a, 0);
    en = 1'b1;
    highs = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (out_a || busy_a) highs++;
    end
    check("en_drop quiet", highs, 0);

    edges = 0;
    prev  = 1'b0;
    for (int k = 0; k <= 44; k++) begin
      in_s = (k <= 5);
      tick();
      c = k + 1;
      if (out_s && !prev) edges++;
      prev = out_s;
      check($sformatf("sat pend c%0d", c), pend_s,
            (c == 2) ? 1 : (c == 3) ? 2 : win(c, 4, 10) ? 3 : win(c, 11, 20) ? 2 :
            win(c, 21, 30) ? 1 : 0);
      check($sformatf("sat ovf c%0d", c), ovf_s, (c >= 5));
    end
    in_s = 1'b0;
    check("sat pulse count", edges, 4);
    en = 1'b0;
    tick();
    en = 1'b1;
    check("sat ovf after en", ovf_s, 1);
    check("sat pend after en", pend_s, 0);

    for (int k = 0; k <= 20; k++) begin
      in_m = (k == 0) || (k == 2) || (k == 12) || (k == 15);
      tick();
      c = k + 1;
      check($sformatf("merge out c%0d", c),  out_m,  win(c, 1, 6) | win(c, 13, 18));
      check($sformatf("merge busy c%0d", c), busy_m, win(c, 1, 6) | win(c, 13, 18));
      check($sformatf("merge pend c%0d", c), pend_m, (c == 3) ? 1 : 0);
    end
    in_m = 1'b0;
`endif

    // async reset mid-HOLD
    for (int k = 0; k <= 3; k++) begin
      in_a = (k == 0) || (k == 2);
      tick();
    end
    in_a = 1'b0;
    check("areset pre out", out_a, 1);
`ifndef PULSE_STRETCH_RETRIGGER_EN
    check("areset pre pend", pend_a, 1);
`endif
    #3 rst_n = 1'b0;
    #1;
    check("areset out",  out_a,  0);
    check("areset busy", busy_a, 0);
    check("areset pend", pend_a, 0);
    tick();
    #4 rst_n = 1'b1;
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_a || busy_a) highs++;
    end
    check("areset no replay", highs, 0);
    in_a = 1'b1;
    tick();
    in_a = 1'b0;
    check("areset new pulse out", out_a, 1);
    check("areset new pulse pend", pend_a, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
